// File: rtl/lab2_serial_adder.sv
// lab2_serial_adder: bit-serial LSB-first adder with one full-add cell, start/busy/done handshake
// Ports: clk/rst (sync, active high); start,a,b in; busy (RUN), done (1-cycle pulse), sum, cout, ovf out.
module lab2_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_s_sh, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_cout, r_cin_msb, r_busy, r_done;
  logic             w_s, w_c;
  assign w_s  = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
  assign w_c  = (r_a_sh[0] & r_b_sh[0]) | (r_c & (r_a_sh[0] ^ r_b_sh[0]));
  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  // signed overflow: carry into the MSB differs from carry out of it
  assign ovf  = r_cout ^ r_cin_msb;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_cin_msb <= 1'b0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_s_sh    <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a_sh  <= a;
          r_b_sh  <= b;
          r_c     <= 1'b0;
          r_cnt   <= '0;
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
        RUN: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_s_sh <= {w_s, r_s_sh[WIDTH-1:1]};
          r_c    <= w_c;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_cin_msb <= r_c;
            r_sum     <= {w_s, r_s_sh[WIDTH-1:1]};
            r_cout    <= w_c;
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lab2_serial_adder.sv
// tb_lab2_serial_adder: randomized self-checking bench against an arithmetic reference model
module tb_lab2_serial_adder;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  int           n_cmp = 0, n_err = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0, last_ovf = 1'b0;
  lab2_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int s;
    logic [W:0] full;
    full = {1'b0, x} + {1'b0, y};
    s = $signed(x) + $signed(y);
    return {(s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1))), full};
  endfunction
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi);
    logic [W+1:0] m;
    logic [31:0]  obs, exp;
    m = model(ai, bi);
    obs = '0;
    exp = '0;
    @(negedge clk);
    start = 1'b1;
    a = ai;
    b = bi;
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      obs[2*k +: 2] = {busy, done};
      exp[2*k +: 2] = (k < W) ? 2'b10 : (k == W) ? 2'b01 : 2'b00;
      if (k == W / 2) check("hold_run", {sum, cout, ovf}, {last_sum, last_cout, last_ovf});
      if (k == W) check("result", {sum, cout, ovf}, {m[W-1:0], m[W], m[W+1]});
    end
    check("timing", obs, exp);
    last_sum = m[W-1:0];
    last_cout = m[W];
    last_ovf = m[W+1];
  endtask
  initial begin
    logic [W-1:0] va[0:19], vb[0:19];
    logic [W+1:0] m;
    logic         saw_done;
    repeat (3) @(negedge clk);
    check("reset", {busy, done, sum, cout, ovf}, '0);
    rst = 1'b0;
    run_op(8'h3C, 8'h05);
    run_op(8'hFF, 8'h01);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_done |= done | busy;
    end
    check("idle_quiet", saw_done, 1'b0);
    check("idle_hold", {sum, cout, ovf}, {8'h00, 1'b1, 1'b0});
    run_op(8'h7F, 8'h01);
    run_op(8'h80, 8'h80);
    // start held high while operands change every cycle
    @(negedge clk);
    va[0] = 8'h10;
    vb[0] = 8'h20;
    start = 1'b1;
    a = va[0];
    b = vb[0];
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (k == W) check("abuse_first", {done, busy, sum}, {1'b1, 1'b0, 8'h30});
      if (k == W + 1) check("abuse_done_ignored", {busy, done}, 2'b00);
      if (k == W + 2) check("abuse_accept", {busy, done}, 2'b10);
      if (k == 2 * W + 2) begin
        m = model(va[W+2], vb[W+2]);
        check("abuse_second", {done, sum, cout, ovf}, {1'b1, m[W-1:0], m[W], m[W+1]});
        last_sum = m[W-1:0];
        last_cout = m[W];
        last_ovf = m[W+1];
      end
      va[k+1] = W'($urandom);
      vb[k+1] = W'($urandom);
      a = va[k+1];
      b = vb[k+1];
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    // reset during RUN
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", {busy, done, sum, cout, ovf}, '0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_done |= done | busy;
    end
    check("no_done_after_abort", saw_done, 1'b0);
    last_sum = '0;
    last_cout = 1'b0;
    last_ovf = 1'b0;
    run_op(8'h01, 8'h02);
    for (int i = 0; i < 1000; i++) run_op(W'($urandom), W'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
